// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed scan controller for a shared registered 7-segment decoder.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS       = 4,
  parameter int DWELL_CYCLES     = 25000,
  parameter int BLANK_CYCLES     = 4,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                          i_CLK,
  input  logic                          i_RST_N,
  input  logic                          i_ENABLE,
  input  logic                          i_LOAD,
  input  logic [4*NUM_DIGITS-1:0]       i_VALUE,
  output logic [3:0]                    o_BINARY,
  output logic [NUM_DIGITS-1:0]         o_DIGIT_SEL,
  output logic [$clog2(NUM_DIGITS)-1:0] o_DIGIT_IDX,
  output logic                          o_FRAME_DONE
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                  r_state,   w_stateNext;
  logic [4*NUM_DIGITS-1:0] r_pending, w_pendingNext;
  logic [4*NUM_DIGITS-1:0] r_shadow,  w_shadowNext;
  logic [IDX_W-1:0]        r_idx,     w_idxNext;
  logic [CNT_W-1:0]        r_cnt,     w_cntNext;
  logic [3:0]              r_binary,  w_binaryNext;
  logic [NUM_DIGITS-1:0]   r_selOn,   w_selOnNext;
  logic                    r_frameDone, w_frameDoneNext;

  logic [4*NUM_DIGITS-1:0] w_newValue;
  logic [IDX_W-1:0]        w_nextIdx;
  logic [3:0]              w_nextNibble;
  logic [NUM_DIGITS-1:0]   w_oneHot;
  logic [NUM_DIGITS-1:0]   w_lit;

  // A load on the same edge that refreshes the shadow bypasses pending.
  assign w_newValue   = i_LOAD ? i_VALUE : r_pending;
  assign w_nextIdx    = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
  assign w_nextNibble = r_shadow[{w_nextIdx, 2'b00} +: 4];
  assign w_oneHot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic w_zeroAbove;

  // Scan from the top digit down; a digit stays dark while everything above it is zero.
  always_comb begin
    w_zeroAbove = 1'b1;
    w_lit       = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zeroAbove = w_zeroAbove & (r_shadow[4*k +: 4] == 4'h0);
      w_lit[k]    = ~w_zeroAbove;
    end
    w_lit[0] = 1'b1;
  end
`else
  assign w_lit = '1;
`endif

  always_comb begin
    w_stateNext     = r_state;
    w_pendingNext   = w_newValue;
    w_shadowNext    = r_shadow;
    w_idxNext       = r_idx;
    w_cntNext       = r_cnt;
    w_binaryNext    = r_binary;
    w_selOnNext     = r_selOn;
    w_frameDoneNext = 1'b0;

    if (r_state == ST_OFF) begin
      w_shadowNext = w_newValue;
    end

    if (!i_ENABLE) begin
      w_stateNext = ST_OFF;
      w_idxNext   = '0;
      w_cntNext   = '0;
      w_selOnNext = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_stateNext  = ST_BLANK;
          w_idxNext    = '0;
          w_cntNext    = '0;
          w_selOnNext  = '0;
          w_binaryNext = w_newValue[3:0];
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_stateNext = ST_SHOW;
            w_cntNext   = '0;
            w_selOnNext = w_lit[r_idx] ? w_oneHot : '0;
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_stateNext = ST_BLANK;
            w_cntNext   = '0;
            w_selOnNext = '0;
            w_idxNext   = w_nextIdx;
            // Frame wrap: the only point where a new value may enter the display.
            if (r_idx == IDX_LAST) begin
              w_shadowNext    = w_newValue;
              w_binaryNext    = w_newValue[3:0];
              w_frameDoneNext = 1'b1;
            end else begin
              w_binaryNext = w_nextNibble;
            end
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
        default: begin
          w_stateNext = ST_OFF;
          w_idxNext   = '0;
          w_cntNext   = '0;
          w_selOnNext = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state     <= ST_OFF;
      r_pending   <= '0;
      r_shadow    <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_binary    <= '0;
      r_selOn     <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_pending   <= w_pendingNext;
      r_shadow    <= w_shadowNext;
      r_idx       <= w_idxNext;
      r_cnt       <= w_cntNext;
      r_binary    <= w_binaryNext;
      r_selOn     <= w_selOnNext;
      r_frameDone <= w_frameDoneNext;
    end
  end

  generate
    if (DIGIT_ACTIVE_LOW != 0) begin : g_selLow
      assign o_DIGIT_SEL = ~r_selOn;
    end else begin : g_selHigh
      assign o_DIGIT_SEL = r_selOn;
    end
  endgenerate

  assign o_BINARY     = r_binary;
  assign o_DIGIT_IDX  = r_idx;
  assign o_FRAME_DONE = r_frameDone;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Bench for seven_seg_scan_controller: directed scenarios plus random traffic against
// a frame/slot-arithmetic reference model (also models SEVEN_SEG_LZ_BLANK_EN when defined).
module tb_seven_seg_scan_controller;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = N * SLOT;

  logic        i_CLK    = 1'b0;
  logic        i_RST_N  = 1'b1;
  logic        i_ENABLE = 1'b0;
  logic        i_LOAD   = 1'b0;
  logic [15:0] i_VALUE  = '0;
  logic [3:0]  o_BINARY;
  logic [3:0]  o_DIGIT_SEL;
  logic [1:0]  o_DIGIT_IDX;
  logic        o_FRAME_DONE;

  int          cmpCount = 0;
  int          errCount = 0;
  string       phase    = "reset";

  // Reference model: enabled time since the scan started, and the value owning the frame.
  bit          mRun;
  int          mT;
  logic [15:0] mFrame;
  logic [15:0] mPend;
  logic [3:0]  mBin;

  seven_seg_scan_controller #(
    .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .DIGIT_ACTIVE_LOW(1)
  ) dut (
    .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_ENABLE(i_ENABLE), .i_LOAD(i_LOAD),
    .i_VALUE(i_VALUE), .o_BINARY(o_BINARY), .o_DIGIT_SEL(o_DIGIT_SEL),
    .o_DIGIT_IDX(o_DIGIT_IDX), .o_FRAME_DONE(o_FRAME_DONE)
  );

  always #5 i_CLK = ~i_CLK;

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic int curDigit();
    return (mT % FRAME) / SLOT;
  endfunction

  function automatic int curWithin();
    return (mT % FRAME) % SLOT;
  endfunction

  task automatic modelReset();
    mRun = 0; mT = 0; mFrame = '0; mPend = '0; mBin = '0;
  endtask

  task automatic modelEdge();
    logic [15:0] newVal;
    newVal = i_LOAD ? i_VALUE : mPend;
    if (!i_ENABLE) begin
      if (!mRun) mFrame = newVal;
      mRun = 0;
      mT   = 0;
    end else if (!mRun) begin
      mRun   = 1;
      mT     = 0;
      mFrame = newVal;
    end else begin
      mT = mT + 1;
      if (mT % FRAME == 0) mFrame = newVal;
    end
    mPend = newVal;
    if (mRun) mBin = nib(mFrame, curDigit());
  endtask

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmpCount++;
    assert (obs === exp)
    else begin
      errCount++;
      $error("[TB] FAIL %s/%s at %0t: got %h expected %h", phase, tag, $time, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] expSel, expIdx;
    logic       expFd;
    bit         lit;
    expSel = 4'b1111;
    expIdx = '0;
    expFd  = 1'b0;
    if (mRun) begin
      expIdx = 4'(curDigit());
      expFd  = (mT > 0) && (mT % FRAME == 0);
      lit    = 1;
`ifdef SEVEN_SEG_LZ_BLANK_EN
      lit = (curDigit() == 0) || ((mFrame >> (4 * curDigit())) != 0);
`endif
      if (curWithin() >= BL && lit) expSel = ~(4'b0001 << curDigit());
    end
    checkVal("sel",  16'(o_DIGIT_SEL),  16'(expSel));
    checkVal("bin",  16'(o_BINARY),     16'(mBin));
    checkVal("idx",  16'(o_DIGIT_IDX),  16'(expIdx[1:0]));
    checkVal("fdon", 16'(o_FRAME_DONE), 16'(expFd));
  endtask

  task automatic applyStimulus(input bit en, input bit ld, input logic [15:0] val);
    i_ENABLE = en;
    i_LOAD   = ld;
    i_VALUE  = val;
    @(posedge i_CLK);
    if (!i_RST_N) modelReset();
    else modelEdge();
    #1;
    i_LOAD = 1'b0;
    checkOutput();
  endtask

  task automatic runCycles(input int n, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000, 16'h0F0F};
    modelReset();

    #1 i_RST_N = 1'b0;
    #1 checkOutput();
    #1 i_RST_N = 1'b1;

    phase = "basic";
    applyStimulus(1'b0, 1'b1, 16'h1234);
    runCycles(2 * FRAME + 5, 1'b1);

    phase = "midload";
    for (int i = 0; i < FRAME && !(curDigit() == 1 && curWithin() >= 4); i++)
      applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'hABCD);
    runCycles(FRAME + 30, 1'b1);

    phase = "wrapload";
    for (int i = 0; i < FRAME && ((mT + 1) % FRAME != 0); i++)
      applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'h5678);
    checkVal("wrapBin", 16'(o_BINARY), 16'h0008);
    runCycles(FRAME, 1'b1);

    phase = "disable";
    for (int i = 0; i < FRAME && !(curDigit() == 2 && curWithin() >= 5); i++)
      applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkVal("offSel", 16'(o_DIGIT_SEL), 16'h000F);
    runCycles(3, 1'b0);
    runCycles(FRAME + 12, 1'b1);

    phase = "asyncrst";
    for (int i = 0; i < FRAME && !(curWithin() >= 4); i++)
      applyStimulus(1'b1, 1'b0, 16'h0);
    #2 i_RST_N = 1'b0;
    #1 modelReset();
    checkOutput();
    runCycles(3, 1'b1);
    i_RST_N = 1'b1;
    runCycles(FRAME + 5, 1'b1);

    phase = "lzero";
    runCycles(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0050);
    runCycles(FRAME + 2, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    runCycles(2 * FRAME, 1'b1);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      bit          en, ld;
      logic [15:0] v;
      en = ($urandom_range(0, 39) != 0);
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom) & masks[$urandom_range(0, 4)];
      applyStimulus(en, ld, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_controller.md
Name: seven_seg_scan_controller

Overview:
Time-multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS common-anode/cathode digits. Holds a frame-consistent copy of the display value, drives the decoder's 4-bit input one digit at a time, and asserts the matching digit select only after the decoder's 1-cycle registered output has settled. Sits between game/score logic (value source) and the decoder plus board digit pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DWELL_CYCLES, 25000, clock cycles each digit is lit (≥1)
BLANK_CYCLES, 4, cycles all selects are inactive before each digit (≥2, covers decoder latency plus anti-ghosting)
DIGIT_ACTIVE_LOW, 1, 1 = select asserted as 0, 0 = asserted as 1

Ports:
i_CLK  in  1  system clock, all logic on rising edge
i_RST_N  in  1  asynchronous active-low reset
i_ENABLE  in  1  1 = scan running, 0 = display off
i_LOAD  in  1  single-cycle strobe, capture i_VALUE
i_VALUE  in  4*NUM_DIGITS  packed nibbles, [3:0] = digit 0 (least significant)
o_BINARY  out  4  nibble to shared decoder input
o_DIGIT_SEL  out  NUM_DIGITS  one-hot digit select (polarity per DIGIT_ACTIVE_LOW)
o_DIGIT_IDX  out  clog2(NUM_DIGITS)  index of digit currently sequenced
o_FRAME_DONE  out  1  one-cycle pulse at end of last digit's dwell

Behaviour:
- Reset (async assert, sync release): state OFF, pending and shadow registers 0, idx 0, o_BINARY 0, o_DIGIT_SEL all inactive, o_FRAME_DONE 0, counters 0. Reset mid-operation takes effect immediately regardless of state.
- States: OFF, BLANK, SHOW. All outputs registered.
- OFF: selects inactive. i_ENABLE=1 -> BLANK, idx=0, o_BINARY=shadow[0].
- BLANK: exactly BLANK_CYCLES cycles, selects inactive, o_BINARY stable. -> SHOW.
- SHOW: exactly DWELL_CYCLES cycles, o_DIGIT_SEL[idx] asserted, others inactive, o_BINARY unchanged. At last SHOW cycle: idx advances (NUM_DIGITS-1 wraps to 0), o_BINARY loaded with the next digit's nibble, -> BLANK. o_DIGIT_SEL drops on the same edge o_BINARY changes.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles. o_FRAME_DONE high for the one cycle after the wrap edge.
- Load: i_LOAD captures i_VALUE into pending. Pending copies to shadow only at the frame wrap edge, or on any edge while in OFF. A frame never mixes old and new digits. i_LOAD on the wrap edge: i_VALUE bypasses directly to shadow and is used for the new frame's digit 0. Multiple loads within a frame: the last one wins.
- i_ENABLE=0 in any state: next edge -> OFF, selects inactive, idx=0, counters cleared, no o_FRAME_DONE. Re-enable restarts at digit 0 BLANK.
- o_DIGIT_IDX equals idx in all states.
- Counters are sized clog2(max(DWELL_CYCLES,BLANK_CYCLES)) and never overflow.

Optional Feature:
SEVEN_SEG_LZ_BLANK_EN. When defined, leading-zero suppression is enabled. Digit k is suppressed if shadow nibbles k..NUM_DIGITS-1 are all 0 and k≠0. A suppressed digit keeps identical timing (BLANK and SHOW still run), but its select stays inactive throughout SHOW. Digit 0 is always shown. When undefined, every digit is lit and no suppression logic is present.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2, DIGIT_ACTIVE_LOW=1):
1. Reset, load 0x1234, enable -> 2 cycles SEL=4'b1111 with o_BINARY=4, then 8 cycles SEL=4'b1110; digits 1,2,3 then show 3,2,1 with SEL 1101/1011/0111; o_FRAME_DONE pulses once per 40 cycles.
2. While running 0x1234, load 0xABCD during digit 1 SHOW -> digits 2,3 still show 2,1; the next frame shows D,C,B,A.
3. Load 0x5678 on the exact wrap edge -> the new frame's digit 0 shows 8 with no frame of stale data.
4. Deassert i_ENABLE mid-SHOW of digit 2 -> next cycle SEL=4'b1111, idx=0, no FRAME_DONE; re-enable -> BLANK then digit 0.
5. Assert i_RST_N=0 asynchronously mid-SHOW -> SEL=4'b1111 and o_BINARY=0 before the next clock edge; after release, shadow=0.
6. With SEVEN_SEG_LZ_BLANK_EN: value 0x0050 -> digits 3,2 keep SEL=1111 during SHOW, digit 1 shows 5, digit 0 shows 0; value 0x0000 -> only digit 0 lit; frame period is still 40 cycles.
